// File: rtl/vec_exec_unit.sv
// vec_exec_unit: multi-cycle SIMD execute stage.
// Lane-wise add/sub/mul/mac over LANES x DW operands, plus cross-lane
// reductions (dot product, sum) through a log2(LANES)-step pairwise adder
// tree that reuses the lane result registers. One writeback strobe per op.
//
// Handshake: an operation is accepted on the rising clk edge where
// in_valid && in_ready. in_ready is high only in IDLE; in_valid while busy
// is ignored (not queued). op/srca/srcb/dest are sampled only at accept.
module vec_exec_unit #(
    parameter int LANES     = 16,
    parameter int DW        = 32,
    parameter int RED_STEPS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [LANES*DW-1:0]   srca,
    input  logic [LANES*DW-1:0]   srcb,
    input  logic [3:0]            dest,
    output logic                  wb_we,
    output logic [3:0]            wb_addr,
    output logic                  wb_vec,
    output logic [2:0]            wb_cmd,
    output logic [LANES*DW-1:0]   wb_data,
    output logic                  busy,
    output logic                  err
);

    localparam int CW = $clog2(RED_STEPS) + 1;

    localparam logic [2:0] OP_VADD    = 3'b000;
    localparam logic [2:0] OP_VSUB    = 3'b001;
    localparam logic [2:0] OP_VMUL    = 3'b010;
    localparam logic [2:0] OP_VMAC    = 3'b011;
    localparam logic [2:0] OP_VDOT    = 3'b100;
    localparam logic [2:0] OP_VREDSUM = 3'b101;
    localparam logic [2:0] OP_ACCCLR  = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RED  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // state is kept as a named register so checkers can bind to it directly
    state_t state;
    state_t state_nxt;

    logic [2:0]    op_q;
    logic [3:0]    dest_q;
    logic [DW-1:0] a_q      [LANES];
    logic [DW-1:0] b_q      [LANES];
    logic [DW-1:0] acc_q    [LANES];
    logic [DW-1:0] res_q    [LANES];
    logic [CW-1:0] red_cnt;

    logic [DW-1:0]       prod     [LANES];
    logic [DW-1:0]       lane_res [LANES];
    logic [DW-1:0]       red_next [LANES];
    logic [LANES*DW-1:0] lane_res_flat;
    logic                last_red;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign last_red = (red_cnt == CW'(RED_STEPS - 1));

    // Lane-wise results for the latched opcode (VMAC yields the new accumulator)
    always_comb begin
        lane_res_flat = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i]     = a_q[i] * b_q[i];
            lane_res[i] = '0;
            case (op_q)
                OP_VADD:    lane_res[i] = a_q[i] + b_q[i];
                OP_VSUB:    lane_res[i] = a_q[i] - b_q[i];
                OP_VMUL:    lane_res[i] = prod[i];
                OP_VMAC:    lane_res[i] = acc_q[i] + prod[i];
                OP_VDOT:    lane_res[i] = prod[i];
                OP_VREDSUM: lane_res[i] = a_q[i];
                default:    lane_res[i] = '0;
            endcase
            lane_res_flat[i*DW +: DW] = lane_res[i];
        end
    end

    // One adder-tree step: lane i takes lanes 2i and 2i+1 while i is in the active half
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            red_next[i] = res_q[i];
        end
        for (int i = 0; i < LANES / 2; i++) begin
            if (i < (LANES >> (int'(red_cnt) + 1))) begin
                red_next[i] = res_q[2*i] + res_q[2*i+1];
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (!op_q[2]) begin
                    state_nxt = S_WB;
                end else if (op_q == OP_VDOT || op_q == OP_VREDSUM) begin
                    state_nxt = S_RED;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RED: begin
                if (last_red) state_nxt = S_WB;
            end
            S_WB: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, lane/accumulator registers and registered writeback outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            dest_q  <= '0;
            red_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_vec  <= 1'b0;
            wb_cmd  <= '0;
            wb_data <= '0;
            err     <= 1'b0;
        end else begin
            wb_we <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        dest_q <= dest;
                        for (int i = 0; i < LANES; i++) begin
                            a_q[i] <= srca[i*DW +: DW];
                            b_q[i] <= srcb[i*DW +: DW];
                        end
                    end
                end
                S_EXEC: begin
                    res_q   <= lane_res;
                    red_cnt <= '0;
                    if (op_q == OP_VMAC) begin
                        acc_q <= lane_res;
                    end
                    if (op_q == OP_ACCCLR) begin
                        for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
                    end
                    if (!op_q[2]) begin
                        wb_we   <= 1'b1;
                        wb_data <= lane_res_flat;
                        wb_addr <= dest_q;
                        wb_cmd  <= op_q;
                        wb_vec  <= 1'b1;
                    end
                    if (op_q == OP_ILLEGAL) begin
                        err <= 1'b1;
                    end
                end
                S_RED: begin
                    res_q   <= red_next;
                    red_cnt <= red_cnt + CW'(1);
                    if (last_red) begin
                        // register file steers the top lane into the scalar file
                        wb_we   <= 1'b1;
                        wb_data <= '0;
                        wb_data[(LANES-1)*DW +: DW] <= red_next[0];
                        wb_addr <= dest_q;
                        wb_cmd  <= OP_VREDSUM;
                        wb_vec  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
